// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per clock, LSB first.
// A start in IDLE captures a/b; WIDTH shift cycles later the result lands in
// diff/borrow_out together with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // counter must be able to represent WIDTH itself
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, pr;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             d, bw_nx, last;

    // full-subtractor cell on the current LSBs
    assign d     = sa[0] ^ sb[0] ^ bw;
    assign bw_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
    assign last  = (cnt == CW'(WIDTH - 1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // datapath: operand capture, serial shift, result publish on the final bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            pr         <= '0;
            cnt        <= '0;
            bw         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        pr  <= '0;
                        cnt <= '0;
                        bw  <= 1'b0;
                    end
                end
                SHIFT: begin
                    pr  <= {d, pr[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    bw  <= bw_nx;
                    cnt <= cnt + CW'(1);
                    // publish directly from the last cell so partials never show
                    if (last) begin
                        diff       <= {d, pr[WIDTH-1:1]};
                        borrow_out <= bw_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vector table plus hand-written sequences for
// start-held-high, mid-operation reset and an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic [7:0] a, b, diff;
    logic [1:0] a2, b2, diff2;
    logic       busy, done, borrow_out;
    logic       busy2, done2, bo2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // one WIDTH=8 operation; reports result, latency (edges after acceptance
    // until done seen), busy cycle count and whether diff stayed put meanwhile
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_,
                       output logic [7:0] rd, output logic rbo,
                       output int lat, output int busyc, output bit stable);
        logic [7:0] prev;
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        prev = diff; lat = 0; busyc = 0; stable = 1'b1;
        while (!done && lat < 50) begin
            if (busy) busyc++;
            if (diff !== prev) stable = 1'b0;
            a = ~a; b = b + 8'd1;   // operands wander after acceptance
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        if (busy) busyc++;
        rd = diff; rbo = borrow_out;
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic op2(input logic [1:0] ta, input logic [1:0] tb_,
                       output logic [1:0] rd, output logic rbo, output int lat);
        @(negedge clk);
        a2 = ta; b2 = tb_; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; lat = 0;
        while (!done2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = diff2; rbo = bo2;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] rd, ea, eb;
        logic [1:0] rd2;
        logic       rbo;
        int         lat, busyc, ndone;
        bit         stable;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
        vecs[6] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1};

        // reset is asynchronous: outputs must be clear before any clock edge
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        a = '0; b = '0; a2 = '0; b2 = '0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // directed vector table
        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, rd, rbo, lat, busyc, stable);
            chk($sformatf("vec%0d_diff", i), {24'd0, rd}, {24'd0, vecs[i].d});
            chk($sformatf("vec%0d_borrow", i), {31'd0, rbo}, {31'd0, vecs[i].bo});
            chk($sformatf("vec%0d_latency", i), lat, 32'd8);
            chk($sformatf("vec%0d_busy_cycles", i), busyc, 32'd9);
            chk($sformatf("vec%0d_diff_stable", i), {31'd0, stable}, 32'd1);
        end

        // start held high, operands changing every cycle: accepts at edges
        // 0,10,20 so done appears after edges 8,18,28
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            a = 8'(k * 7 + 3); b = 8'(k * 13 + 1); start = 1'b1;
            @(posedge clk); #1;
            if (done) begin
                ea = 8'((k - 8) * 7 + 3);
                eb = 8'((k - 8) * 13 + 1);
                chk("hold_done_edge", k, 8 + 10 * ndone);
                chk("hold_diff", {24'd0, diff}, {24'd0, 8'(ea - eb)});
                chk("hold_borrow", {31'd0, borrow_out}, {31'd0, ea < eb});
                ndone++;
            end
        end
        chk("hold_done_count", ndone, 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);

        // reset during the 4th SHIFT cycle aborts with no done pulse
        @(negedge clk);
        a = 8'h55; b = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_borrow", {31'd0, borrow_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);
        op8(8'd7, 8'd2, rd, rbo, lat, busyc, stable);
        chk("after_abort_diff", {24'd0, rd}, 32'h05);
        chk("after_abort_borrow", {31'd0, rbo}, 32'd0);
        chk("after_abort_latency", lat, 32'd8);

        // WIDTH=2 exhaustive against plain subtraction
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                op2(2'(i), 2'(j), rd2, rbo, lat);
                chk($sformatf("w2_%0d_%0d_diff", i, j), {30'd0, rd2}, 32'((i - j) & 3));
                chk($sformatf("w2_%0d_%0d_borrow", i, j), {31'd0, rbo}, {31'd0, i < j});
                chk($sformatf("w2_%0d_%0d_latency", i, j), lat, 32'd2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that diff and borrow_out hold a new result.
REQ-009 The block SHALL have port diff, output, WIDTH bits: registered result, a minus b modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit: final borrow, 1 iff a < b unsigned.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 at an edge, the block SHALL load a and b into internal shift registers, clear the borrow flop and bit counter, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit LSB-first with the full-subtractor cell: d = a0^b0^bw; bw_next = (~a0&b0) | (~(a0^b0)&bw).
REQ-014 In SHIFT, d SHALL be shifted into the MSB of an internal partial-result register, the operand registers shifted right by one, and the counter incremented.
REQ-015 After exactly WIDTH SHIFT edges, the block SHALL copy the partial result to diff and the final borrow to borrow_out, and enter DONE.
REQ-016 Latency: if start is accepted at edge N, done SHALL be high for the cycle after edge N+WIDTH, and for that cycle only.
REQ-017 DONE SHALL last one cycle and return to IDLE on the next edge unconditionally.
REQ-018 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-019 start SHALL be ignored in SHIFT and DONE; an operation in flight is never restarted or corrupted.
REQ-020 The earliest back-to-back acceptance is the first edge in IDLE after DONE.
REQ-021 diff and borrow_out SHALL change only on entry to DONE and hold their values until the next completion; partial results are never visible.
REQ-022 Changes on a and b after acceptance SHALL have no effect on the result.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH; the counter SHALL be wide enough to hold WIDTH without wrapping.

Reset
REQ-024 While rst=1, the block SHALL force state=IDLE and set busy=0, done=0, diff=0, borrow_out=0, and clear the counter, borrow flop and shift registers, regardless of clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-026 a=5, b=3, start for one cycle -> busy high for 9 cycles, done pulses 8 edges after acceptance, diff=0x02, borrow_out=0.
REQ-027 a=3, b=5 -> diff=0xFE, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-028 a=0xFF, b=0xFF and a=0, b=0 -> diff=0x00, borrow_out=0 in both cases; a=0xA5, b=0x5A -> diff=0x4B, borrow_out=0.
REQ-029 start held high continuously with a and b changed every cycle -> operations are accepted only from IDLE, and each result matches the operands captured at acceptance.
REQ-030 rst pulsed on the 4th SHIFT cycle -> outputs are zero immediately, no done pulse occurs, and a following 7-2 yields diff=0x05, borrow_out=0.
REQ-031 All 8 single-bit combinations of a0, b0 and incoming borrow, exercised with WIDTH=2 operands -> diff and borrow_out match the full-subtractor truth table and an exhaustive reference model.
